// File: rtl/otp_ctrl_lc_rdout.sv
// -----------------------------------------------------------------------------
// otp_ctrl_lc_rdout
//   Read side of the OTP life cycle partition. After power-up it reads every
//   16-bit native word of the LC partition, one request at a time, assembles
//   them into a flat vector and flags it valid for lc_ctrl. Correctable ECC
//   errors are recorded and the readout continues. Any other macro error,
//   escalation, an illegal FSM encoding or a counter fault parks the block in
//   a terminal error state with the data output blanked.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   rd_en_i          level, starts the readout when seen in IdleSt
//   escalate_en_i    lc_tx_t escalation, anything but Off counts as asserted
//   otp_req_o/gnt_i  OTP macro request handshake (always a 1-word Read)
//   otp_cmd_o        command (Read)
//   otp_size_o       size field (0 = one native word)
//   otp_addr_o       native-word address = partition base + word counter
//   otp_rvalid_i     response strobe with otp_rdata_i / otp_err_i
//   lc_data_o        assembled partition, word k at [k*16 +: 16]
//   lc_valid_o       data complete, no uncorrectable error
//   error_o          latched otp_err_e code
//   fsm_err_o        invalid state, escalation or counter fault
//   rdout_idle_o     low while a transaction is in flight
// -----------------------------------------------------------------------------
module otp_ctrl_lc_rdout #(
  parameter  int unsigned LcOffset         = 1704,
  parameter  int unsigned LcSize           = 88,
  localparam int unsigned OtpAddrWidth     = 10,
  localparam int unsigned OtpSizeWidth     = 2,
  localparam int unsigned ScrmblBlockWidth = 64,
  localparam int unsigned LcDataWidth      = LcSize * 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rd_en_i,
  input  logic [3:0]                  escalate_en_i,
  output logic                        otp_req_o,
  output logic [2:0]                  otp_cmd_o,
  output logic [OtpSizeWidth-1:0]     otp_size_o,
  output logic [OtpAddrWidth-1:0]     otp_addr_o,
  input  logic                        otp_gnt_i,
  input  logic                        otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0] otp_rdata_i,
  input  logic [2:0]                  otp_err_i,
  output logic [LcDataWidth-1:0]      lc_data_o,
  output logic                        lc_valid_o,
  output logic [2:0]                  error_o,
  output logic                        fsm_err_o,
  output logic                        rdout_idle_o
);

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned OtpAddrShift = 1;
  localparam int unsigned NumWords     = LcSize >> OtpAddrShift;
  localparam int unsigned CntWidth     = (NumWords <= 1) ? 1 : $clog2(NumWords);
  localparam logic [OtpAddrWidth-1:0] OffsetWord = OtpAddrWidth'(LcOffset >> OtpAddrShift);
  localparam logic [CntWidth-1:0]     LastCnt    = CntWidth'(NumWords - 1);

  // otp_err_e / prim_otp_pkg::err_e codes
  localparam logic [2:0] NoError           = 3'd0;
  localparam logic [2:0] MacroEccCorrError = 3'd2;
  localparam logic [2:0] FsmStateError     = 3'd7;
  localparam logic [2:0] CmdRead           = 3'd0;
  localparam logic [3:0] LcTxOff           = 4'b1010;

  // Encodings are pairwise at least 5 bits apart.
  typedef enum logic [8:0] {
    ResetSt    = 9'b000000000,
    IdleSt     = 9'b111110000,
    ReadSt     = 9'b110001110,
    ReadWaitSt = 9'b001101101,
    DoneSt     = 9'b101011011,
    ErrorSt    = 9'b010110111
  } state_e;

  logic [8:0]                          r_state;
  state_e                              w_state_q, w_state_d;
  logic [NumWords-1:0][DATA_W-1:0]     r_data;
  logic [CntWidth-1:0]                 r_cnt, r_cnt_b;
  logic [2:0]                          r_error, w_error_d;
  logic                                r_valid;
  logic                                w_cnt_clr, w_cnt_en, w_cnt_err;
  logic                                w_data_we, w_fsm_err, w_esc;
  logic                                w_unused;

  assign w_state_q = state_e'(r_state);
  assign w_esc     = (escalate_en_i != LcTxOff);
  assign w_unused  = ^otp_rdata_i[ScrmblBlockWidth-1:DATA_W];

  // Word counter kept as a true and a complemented copy; any disagreement
  // means a flop was upset and is treated like escalation.
  assign w_cnt_err = (r_cnt != ~r_cnt_b);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_cnt_b <= '1;
    end else if (w_cnt_clr) begin
      r_cnt   <= '0;
      r_cnt_b <= '1;
    end else if (w_cnt_en) begin
      r_cnt   <= r_cnt + 1'b1;
      r_cnt_b <= r_cnt_b - 1'b1;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_error_d = r_error;
    otp_req_o = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    w_data_we = 1'b0;
    w_fsm_err = 1'b0;
    case (w_state_q)
      ResetSt: w_state_d = IdleSt;
      IdleSt: begin
        if (rd_en_i) begin
          w_cnt_clr = 1'b1;
          w_state_d = ReadSt;
        end
      end
      ReadSt: begin
        otp_req_o = 1'b1;
        if (otp_gnt_i) w_state_d = ReadWaitSt;
      end
      ReadWaitSt: begin
        if (otp_rvalid_i) begin
          w_data_we = 1'b1;
          if (otp_err_i == NoError || otp_err_i == MacroEccCorrError) begin
            if (otp_err_i == MacroEccCorrError && r_error == NoError) w_error_d = MacroEccCorrError;
            if (r_cnt == LastCnt) begin
              w_state_d = DoneSt;
            end else begin
              w_cnt_en  = 1'b1;
              w_state_d = ReadSt;
            end
          end else begin
            // Uncorrectable: abort the readout with the macro's code.
            w_error_d = otp_err_i;
            w_state_d = ErrorSt;
          end
        end
      end
      DoneSt: ;
      ErrorSt: begin
        if (r_error == NoError) w_error_d = FsmStateError;
      end
      default: begin
        w_state_d = ErrorSt;
        w_fsm_err = 1'b1;
        if (r_error == NoError) w_error_d = FsmStateError;
      end
    endcase

    // Escalation and counter faults override everything, including a
    // response arriving in the same cycle, which is then dropped.
    if (w_esc || w_cnt_err) begin
      w_state_d = ErrorSt;
      w_fsm_err = 1'b1;
      w_data_we = 1'b0;
      w_cnt_en  = 1'b0;
      w_cnt_clr = 1'b0;
      w_error_d = (r_error == NoError) ? FsmStateError : r_error;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ResetSt;
      r_error <= NoError;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_error <= w_error_d;
      r_valid <= (w_state_d == DoneSt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
    end else if (w_data_we) begin
      r_data[r_cnt] <= otp_rdata_i[DATA_W-1:0];
    end
  end

  assign otp_cmd_o    = CmdRead;
  assign otp_size_o   = '0;
  assign otp_addr_o   = OffsetWord + OtpAddrWidth'(r_cnt);
  assign lc_data_o    = (w_state_q == ErrorSt) ? '0 : r_data;
  assign lc_valid_o   = r_valid;
  assign error_o      = r_error;
  assign fsm_err_o    = w_fsm_err;
  assign rdout_idle_o = !(w_state_q == ReadSt || w_state_q == ReadWaitSt);

endmodule

// File: tb/tb_otp_ctrl_lc_rdout.sv
`timescale 1ns/1ps
module tb_otp_ctrl_lc_rdout;

  localparam int         NW     = 44;
  localparam int         DW     = NW * 16;
  localparam logic [9:0] BASE   = 10'd852;   // 1704 bytes >> 1
  localparam logic [3:0] LC_OFF = 4'b1010;
  localparam logic [3:0] LC_ON  = 4'b0101;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rd_en_i = 1'b0;
  logic [3:0]    escalate_en_i;
  logic          otp_req_o;
  logic [2:0]    otp_cmd_o;
  logic [1:0]    otp_size_o;
  logic [9:0]    otp_addr_o;
  logic          otp_gnt_i;
  logic          otp_rvalid_i;
  logic [63:0]   otp_rdata_i;
  logic [2:0]    otp_err_i;
  logic [DW-1:0] lc_data_o;
  logic          lc_valid_o;
  logic [2:0]    error_o;
  logic          fsm_err_o;
  logic          rdout_idle_o;

  always #5 clk_i = ~clk_i;

  otp_ctrl_lc_rdout dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rd_en_i       (rd_en_i),
    .escalate_en_i (escalate_en_i),
    .otp_req_o     (otp_req_o),
    .otp_cmd_o     (otp_cmd_o),
    .otp_size_o    (otp_size_o),
    .otp_addr_o    (otp_addr_o),
    .otp_gnt_i     (otp_gnt_i),
    .otp_rvalid_i  (otp_rvalid_i),
    .otp_rdata_i   (otp_rdata_i),
    .otp_err_i     (otp_err_i),
    .lc_data_o     (lc_data_o),
    .lc_valid_o    (lc_valid_o),
    .error_o       (error_o),
    .fsm_err_o     (fsm_err_o),
    .rdout_idle_o  (rdout_idle_o)
  );

  // Per-test configuration of the OTP macro model.
  logic [15:0] mem     [NW];
  logic [2:0]  err_tab [NW];
  int          gnt_dly [NW];
  int          esc_word = -1;
  logic [3:0]  esc_val  = LC_ON;
  bit          late_inject = 1'b0;
  int          req_bad = 0;     // requests with wrong addr/cmd/size or past the end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // OTP macro model: grants after gnt_dly cycles, answers the cycle after grant.
  initial begin : otp_model
    int  widx, pidx, wait_cnt;
    bit  pending;
    widx = 0; pidx = 0; wait_cnt = 0; pending = 1'b0;
    otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_rdata_i = '0; otp_err_i = '0;
    escalate_en_i = LC_OFF;
    forever begin
      @(negedge clk_i);
      otp_gnt_i    = 1'b0;
      otp_rvalid_i = 1'b0;
      otp_err_i    = 3'd0;
      otp_rdata_i  = {$urandom, $urandom};
      if (!rst_ni) begin
        widx = 0; pending = 1'b0; wait_cnt = 0;
        escalate_en_i = LC_OFF;
      end else if (late_inject) begin
        otp_rvalid_i = 1'b1;
        otp_err_i    = 3'd3;
      end else if (pending) begin
        pending = 1'b0;
        otp_rvalid_i = 1'b1;
        otp_rdata_i[15:0] = mem[pidx];
        otp_err_i = err_tab[pidx];
        if (pidx == esc_word) escalate_en_i = esc_val;
        widx++;
      end else if (otp_req_o) begin
        if (widx >= NW) begin
          req_bad++;
        end else begin
          if (otp_addr_o !== BASE + 10'(widx) || otp_cmd_o !== 3'd0 || otp_size_o !== 2'd0)
            req_bad++;
          if (wait_cnt >= gnt_dly[widx]) begin
            otp_gnt_i = 1'b1;
            pending   = 1'b1;
            pidx      = widx;
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Reference: walk the words in order applying the readout rules.
  task automatic model(output logic [2:0] e_err, output bit e_ok, output logic [DW-1:0] e_data,
                       output int e_lat, output bit e_esc);
    e_err = 3'd0; e_ok = 1'b1; e_data = '0; e_lat = 1; e_esc = 1'b0;
    for (int k = 0; k < NW; k++) begin
      e_lat += 2 + gnt_dly[k];
      if (k == esc_word) begin
        e_esc = 1'b1;
        if (e_err == 3'd0) e_err = 3'd7;
        e_ok = 1'b0;
        break;
      end
      if (err_tab[k] == 3'd2) begin
        if (e_err == 3'd0) e_err = 3'd2;
      end else if (err_tab[k] != 3'd0) begin
        e_err = err_tab[k];
        e_ok  = 1'b0;
        break;
      end
      e_data[k*16 +: 16] = mem[k];
    end
    if (!e_ok) e_data = '0;
  endtask

  task automatic set_clean();
    for (int k = 0; k < NW; k++) begin
      mem[k]     = 16'hA500 + 16'(k);
      err_tab[k] = 3'd0;
      gnt_dly[k] = 0;
    end
    esc_word = -1;
    esc_val  = LC_ON;
  endtask

  task automatic set_random();
    int r;
    for (int k = 0; k < NW; k++) begin
      mem[k]     = 16'($urandom);
      gnt_dly[k] = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 5)      err_tab[k] = 3'd2;
      else if (r < 7) err_tab[k] = (r == 5) ? 3'd3 : ((($urandom & 1) != 0) ? 3'd1 : 3'd4);
      else            err_tab[k] = 3'd0;
    end
    esc_word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
    esc_val  = 4'($urandom);
    if (esc_val == LC_OFF) esc_val = LC_ON;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni  = 1'b0;
    rd_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic run_case(input string name);
    logic [2:0]    e_err;
    bit            e_ok, e_esc, done;
    logic [DW-1:0] e_data;
    int            e_lat, n, extra, bad0;
    model(e_err, e_ok, e_data, e_lat, e_esc);
    bad0 = req_bad;
    rd_en_i = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
      if (rdout_idle_o) done = 1'b1;
    end
    chk({name, "_finished"}, DW'(done), DW'(1));
    chk({name, "_latency"},  DW'(n), DW'(e_lat));
    chk({name, "_valid"},    DW'(lc_valid_o), DW'(e_ok));
    chk({name, "_error"},    DW'(error_o), DW'(e_err));
    chk({name, "_data"},     lc_data_o, e_data);
    chk({name, "_fsm_err"},  DW'(fsm_err_o), DW'(e_esc));
    if (e_esc) chk({name, "_esc_word_dropped"}, DW'(dut.r_data[esc_word]), DW'(0));
    extra = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (otp_req_o) extra++;
    end
    chk({name, "_req_after_end"}, DW'(extra), DW'(0));
    chk({name, "_req_protocol"},  DW'(req_bad - bad0), DW'(0));
    chk({name, "_valid_hold"},    DW'(lc_valid_o), DW'(e_ok));
    @(negedge clk_i);
    rd_en_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    set_clean();
    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid",   DW'(lc_valid_o), DW'(0));
    chk("rst_error",   DW'(error_o), DW'(0));
    chk("rst_data",    lc_data_o, '0);
    chk("rst_req",     DW'(otp_req_o), DW'(0));
    chk("rst_fsm_err", DW'(fsm_err_o), DW'(0));
    chk("rst_cmd",     DW'(otp_cmd_o), DW'(0));
    chk("rst_size",    DW'(otp_size_o), DW'(0));
    chk("rst_idle",    DW'(rdout_idle_o), DW'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Clean readout: 89 cycles, A500..A52B
    set_clean();
    run_case("clean");
    chk("clean_word0",  DW'(lc_data_o[15:0]), DW'(16'hA500));
    chk("clean_word43", DW'(lc_data_o[703:688]), DW'(16'hA52B));

    // Correctable ECC on word 3
    do_reset(); set_clean(); err_tab[3] = 3'd2;
    run_case("ecc_corr_w3");

    // Uncorrectable ECC on word 7
    do_reset(); set_clean(); err_tab[7] = 3'd3;
    run_case("ecc_uncorr_w7");

    // Grant held off 5 cycles on word 0 (request stability checked by the macro model)
    do_reset(); set_clean(); gnt_dly[0] = 5;
    run_case("gnt_delay5");

    // Escalation together with the rvalid of word 10
    do_reset(); set_clean(); esc_word = 10; esc_val = LC_ON;
    run_case("escalate_w10");

    // Escalation after a correctable error keeps the earlier code
    do_reset(); set_clean(); err_tab[2] = 3'd2; esc_word = 5; esc_val = 4'b0000;
    run_case("escalate_after_corr");

    // Illegal state encoding
    do_reset();
    @(negedge clk_i);
    force dut.r_state = 9'h1FF;
    #1;
    chk("illegal_fsm_err", DW'(fsm_err_o), DW'(1));
    @(posedge clk_i); #1;
    chk("illegal_error", DW'(error_o), DW'(7));
    @(negedge clk_i);
    release dut.r_state;
    rd_en_i = 1'b1;
    @(posedge clk_i); #1;
    chk("illegal_idle",  DW'(rdout_idle_o), DW'(1));
    chk("illegal_valid", DW'(lc_valid_o), DW'(0));
    repeat (3) @(posedge clk_i);
    #1;
    chk("illegal_terminal_req", DW'(otp_req_o), DW'(0));
    chk("illegal_terminal_err", DW'(error_o), DW'(7));
    chk("illegal_fsm_err_clr",  DW'(fsm_err_o), DW'(0));
    @(negedge clk_i);
    rd_en_i = 1'b0;

    // Reset in the middle of a readout, then a stray rvalid while idle
    do_reset(); set_clean();
    rd_en_i = 1'b1;
    repeat (9) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_data",  lc_data_o, '0);
    chk("midrst_idle",  DW'(rdout_idle_o), DW'(1));
    chk("midrst_req",   DW'(otp_req_o), DW'(0));
    rd_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    late_inject = 1'b1;
    repeat (3) @(negedge clk_i);
    late_inject = 1'b0;
    #1;
    chk("late_rvalid_error", DW'(error_o), DW'(0));
    chk("late_rvalid_data",  lc_data_o, '0);
    chk("late_rvalid_idle",  DW'(rdout_idle_o), DW'(1));
    chk("late_rvalid_fsm",   DW'(fsm_err_o), DW'(0));
    @(negedge clk_i);
    run_case("after_midrst");

    // Randomized readouts
    for (int t = 0; t < 12; t++) begin
      do_reset();
      set_random();
      run_case($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
